// File: rtl/seg7_pkg.sv
// Shared constants for the scanned 7-segment decoder: active-high segment
// patterns (seg[0]=a .. seg[6]=g) and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_A     = 7'h77;
  localparam logic [6:0] SEG7_B     = 7'h7C;
  localparam logic [6:0] SEG7_C     = 7'h39;
  localparam logic [6:0] SEG7_D     = 7'h5E;
  localparam logic [6:0] SEG7_E     = 7'h79;
  localparam logic [6:0] SEG7_F     = 7'h71;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_HOLD
  } state_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Frame output bus of the scan decoder: recovered digits plus valid/ready
// handshake. The decoder drives the master side, the consumer the slave side.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] frame_digits;
  logic [NUM_DIGITS-1:0]   frame_blank;
  logic                    frame_err;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    overrun;

  modport master (
    output frame_digits,
    output frame_blank,
    output frame_err,
    output frame_valid,
    output overrun,
    input  frame_ready
  );

  modport slave (
    input  frame_digits,
    input  frame_blank,
    input  frame_err,
    input  frame_valid,
    input  overrun,
    output frame_ready
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment pattern -> {value, blank, err} lookup.
// Define SEG7_HEX_EN to accept the A..F patterns as legal hex digits.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_value,
  output logic       o_blank,
  output logic       o_err
);

  always_comb begin
    o_value = 4'h0;
    o_blank = 1'b0;
    o_err   = 1'b0;
    case (i_seg)
      SEG7_BLANK: o_blank = 1'b1;
      SEG7_0:     o_value = 4'h0;
      SEG7_1:     o_value = 4'h1;
      SEG7_2:     o_value = 4'h2;
      SEG7_3:     o_value = 4'h3;
      SEG7_4:     o_value = 4'h4;
      SEG7_5:     o_value = 4'h5;
      SEG7_6:     o_value = 4'h6;
      SEG7_7:     o_value = 4'h7;
      SEG7_8:     o_value = 4'h8;
      SEG7_9:     o_value = 4'h9;
`ifdef SEG7_HEX_EN
      SEG7_A:     o_value = 4'hA;
      SEG7_B:     o_value = 4'hB;
      SEG7_C:     o_value = 4'hC;
      SEG7_D:     o_value = 4'hD;
      SEG7_E:     o_value = 4'hE;
      SEG7_F:     o_value = 4'hF;
`endif
      default:    o_err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, captures each digit once it has been
// stable long enough, and presents complete frames on a valid/ready bus.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_seg_in,
  input  logic [NUM_DIGITS-1:0] i_dig_sel,
  seg7_scan_decoder_if.master   frameIf
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [6:0]              r_seg;
  logic [6:0]              r_segPrev;
  logic [NUM_DIGITS-1:0]   r_dig;
  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_stageDigits;
  logic [NUM_DIGITS-1:0]   r_stageBlank;
  logic [NUM_DIGITS-1:0]   r_stageErr;
  logic [4*NUM_DIGITS-1:0] r_outDigits;
  logic [NUM_DIGITS-1:0]   r_outBlank;
  logic                    r_outErr;
  logic                    r_outValid;
  logic                    r_overrun;

  state_t                  w_stateNext;
  logic [IDX_W-1:0]        w_idxNext;
  logic [CNT_W-1:0]        w_cntNext;
  logic                    w_capture;
  logic                    w_frameDone;
  logic [NUM_DIGITS-1:0]   w_expSel;
  logic                    w_digMatch;
  logic [3:0]              w_value;
  logic                    w_blank;
  logic                    w_err;

  assign w_expSel   = NUM_DIGITS'(1) << r_idx;
  assign w_digMatch = (r_dig == w_expSel);

  seg7_pattern_decode u_decode (
    .i_seg   (r_seg),
    .o_value (w_value),
    .o_blank (w_blank),
    .o_err   (w_err)
  );

  // Counting restarts whenever the pattern moves, so only a run of identical samples captures
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_cntNext   = r_cnt;
    w_capture   = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_digMatch) begin
          w_cntNext = CNT_W'(1);
          if (STABLE_CYCLES <= 1) begin
            w_capture   = 1'b1;
            w_stateNext = S_HOLD;
          end else begin
            w_stateNext = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (!w_digMatch) begin
          w_stateNext = S_WAIT;
          w_cntNext   = '0;
        end else begin
          if (r_seg != r_segPrev) w_cntNext = CNT_W'(1);
          else                    w_cntNext = r_cnt + CNT_W'(1);
          if (w_cntNext == CNT_W'(STABLE_CYCLES)) begin
            w_capture   = 1'b1;
            w_stateNext = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!w_digMatch) begin
          w_stateNext = S_WAIT;
          w_cntNext   = '0;
          if (r_idx == LAST_IDX) begin
            w_idxNext   = '0;
            w_frameDone = 1'b1;
          end else begin
            w_idxNext = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_stateNext = S_WAIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg         <= '0;
      r_segPrev     <= '0;
      r_dig         <= '0;
      r_state       <= S_WAIT;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_stageDigits <= '0;
      r_stageBlank  <= '0;
      r_stageErr    <= '0;
      r_outDigits   <= '0;
      r_outBlank    <= '0;
      r_outErr      <= 1'b0;
      r_outValid    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_seg     <= i_seg_in;
      r_segPrev <= r_seg;
      r_dig     <= i_dig_sel;
      r_state   <= w_stateNext;
      r_idx     <= w_idxNext;
      r_cnt     <= w_cntNext;

      // Digit 0 opens a new frame, so stale flags from the last frame are wiped first
      if (w_capture) begin
        if (r_idx == '0) begin
          r_stageBlank <= '0;
          r_stageErr   <= '0;
        end
        r_stageDigits[{r_idx, 2'b00} +: 4] <= w_value;
        r_stageBlank[r_idx]                <= w_blank;
        r_stageErr[r_idx]                  <= w_err;
      end

      if (w_frameDone && (!r_outValid || frameIf.frame_ready)) begin
        r_outDigits <= r_stageDigits;
        r_outBlank  <= r_stageBlank;
        r_outErr    <= |r_stageErr;
        r_outValid  <= 1'b1;
      end else if (w_frameDone) begin
        r_overrun <= 1'b1;
      end else if (r_outValid && frameIf.frame_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign frameIf.frame_digits = r_outDigits;
  assign frameIf.frame_blank  = r_outBlank;
  assign frameIf.frame_err    = r_outErr;
  assign frameIf.frame_valid  = r_outValid;
  assign frameIf.overrun      = r_overrun;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// Expected hex-digit handling follows SEG7_HEX_EN, as in the design.
module tb_seg7_scan_decoder;

  localparam int HOLD = 8;

  typedef struct {
    logic [27:0] pats;
    logic [15:0] expDigits;
    logic [3:0]  expBlank;
    logic        expErr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] dig_sel;

  int checks = 0;
  int errors = 0;

  int          accCount  = 0;
  logic [15:0] accDigits = '0;
  logic [3:0]  accBlank  = '0;
  logic        accErr    = 1'b0;

  logic [6:0] legalPat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  vec_t vecs [5];

  seg7_scan_decoder_if #(.NUM_DIGITS(4)) frameIf ();

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_seg_in  (seg_in),
    .i_dig_sel (dig_sel),
    .frameIf   (frameIf)
  );

  always #5 clk = ~clk;

  // Record every accepted frame, sampled half a cycle away from the active edge
  always @(negedge clk) begin
    if (frameIf.frame_valid && frameIf.frame_ready) begin
      accCount  <= accCount + 1;
      accDigits <= frameIf.frame_digits;
      accBlank  <= frameIf.frame_blank;
      accErr    <= frameIf.frame_err;
    end
  end

  function automatic void refDecode(input logic [6:0] pat, output logic [3:0] val,
                                    output logic blank, output logic err);
    int numLegal;
`ifdef SEG7_HEX_EN
    numLegal = 16;
`else
    numLegal = 10;
`endif
    val   = 4'h0;
    blank = (pat == 7'h00);
    err   = !blank;
    for (int i = 0; i < numLegal; i++) begin
      if (pat == legalPat[i]) begin
        val = 4'(i);
        err = 1'b0;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] sel, input int cycles);
    seg_in  = seg;
    dig_sel = sel;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic scanFrame(input logic [27:0] pats, input int hold);
    for (int d = 0; d < 4; d++) begin
      applyStimulus(pats[7*d +: 7], 4'(1 << d), hold);
      applyStimulus(7'h00, 4'b0000, 1);
    end
  endtask

  task automatic waitAccept(input int target, input string name);
    int n;
    n = 0;
    while (accCount < target && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, " accept count"}, accCount, target);
  endtask

  task automatic checkFrame(input string name, input logic [15:0] d, input logic [3:0] b, input logic e);
    checkOutput({name, " digits"}, accDigits, d);
    checkOutput({name, " blank"}, accBlank, b);
    checkOutput({name, " err"}, accErr, e);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(7'h00, 4'b0000, 2);
    rst = 1'b0;
  endtask

  initial begin : main
    int          target;
    logic [27:0] pats;
    logic [15:0] eD;
    logic [3:0]  eB;
    logic        eE;
    logic [3:0]  v;
    logic        b;
    logic        e;
    logic [6:0]  p;
    int          k;

    vecs[0] = '{pats: {7'h66, 7'h4F, 7'h5B, 7'h06}, expDigits: 16'h4321, expBlank: 4'b0000, expErr: 1'b0};
    vecs[1] = '{pats: {7'h00, 7'h4F, 7'h49, 7'h06}, expDigits: 16'h0301, expBlank: 4'b1000, expErr: 1'b1};
    vecs[2] = '{pats: {7'h3F, 7'h3F, 7'h3F, 7'h3F}, expDigits: 16'h0000, expBlank: 4'b0000, expErr: 1'b0};
    vecs[3] = '{pats: {7'h6F, 7'h6F, 7'h6F, 7'h6F}, expDigits: 16'h9999, expBlank: 4'b0000, expErr: 1'b0};
`ifdef SEG7_HEX_EN
    vecs[4] = '{pats: {7'h4F, 7'h5B, 7'h06, 7'h77}, expDigits: 16'h321A, expBlank: 4'b0000, expErr: 1'b0};
`else
    vecs[4] = '{pats: {7'h4F, 7'h5B, 7'h06, 7'h77}, expDigits: 16'h3210, expBlank: 4'b0000, expErr: 1'b1};
`endif

    rst = 1'b1;
    seg_in = 7'h00;
    dig_sel = 4'b0000;
    frameIf.frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset valid", frameIf.frame_valid, 1'b0);
    checkOutput("reset digits", frameIf.frame_digits, 16'h0000);
    checkOutput("reset blank", frameIf.frame_blank, 4'b0000);
    checkOutput("reset err", frameIf.frame_err, 1'b0);
    checkOutput("reset overrun", frameIf.overrun, 1'b0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 5; i++) begin
      target = accCount + 1;
      scanFrame(vecs[i].pats, HOLD);
      waitAccept(target, $sformatf("vec%0d", i));
      checkFrame($sformatf("vec%0d", i), vecs[i].expDigits, vecs[i].expBlank, vecs[i].expErr);
      checkOutput($sformatf("vec%0d valid drop", i), frameIf.frame_valid, 1'b0);
    end

    $display("[TB] ignored strobes and unstable digit");
    target = accCount + 1;
    applyStimulus(7'h7F, 4'b0011, 6);
    applyStimulus(7'h7F, 4'b0010, 6);
    applyStimulus(7'h00, 4'b0000, 1);
    applyStimulus(7'h06, 4'b0001, HOLD);
    applyStimulus(7'h00, 4'b0000, 1);
    applyStimulus(7'h5B, 4'b0010, HOLD);
    applyStimulus(7'h00, 4'b0000, 1);
    for (int t = 0; t < 3; t++) begin
      applyStimulus(7'h5B, 4'b0100, 2);
      applyStimulus(7'h4F, 4'b0100, 2);
    end
    applyStimulus(7'h5B, 4'b0100, 2);
    applyStimulus(7'h4F, 4'b0100, HOLD);
    applyStimulus(7'h00, 4'b0000, 1);
    applyStimulus(7'h66, 4'b1000, HOLD);
    applyStimulus(7'h00, 4'b0000, 1);
    waitAccept(target, "settle");
    checkFrame("settle", 16'h4321, 4'b0000, 1'b0);

    $display("[TB] overrun with ready low");
    frameIf.frame_ready = 1'b0;
    scanFrame({4{7'h3F}}, HOLD);
    applyStimulus(7'h00, 4'b0000, 2);
    checkOutput("ovr first valid", frameIf.frame_valid, 1'b1);
    checkOutput("ovr first digits", frameIf.frame_digits, 16'h0000);
    checkOutput("ovr first overrun", frameIf.overrun, 1'b0);
    scanFrame({4{7'h6F}}, HOLD);
    applyStimulus(7'h00, 4'b0000, 2);
    checkOutput("ovr hold valid", frameIf.frame_valid, 1'b1);
    checkOutput("ovr hold digits", frameIf.frame_digits, 16'h0000);
    checkOutput("ovr sticky", frameIf.overrun, 1'b1);
    target = accCount + 1;
    frameIf.frame_ready = 1'b1;
    waitAccept(target, "ovr");
    checkOutput("ovr accepted digits", accDigits, 16'h0000);
    checkOutput("ovr valid drop", frameIf.frame_valid, 1'b0);
    checkOutput("ovr still sticky", frameIf.overrun, 1'b1);

    $display("[TB] accept coincident with frame completion");
    doReset();
    checkOutput("rst clears overrun", frameIf.overrun, 1'b0);
    frameIf.frame_ready = 1'b0;
    scanFrame({4{7'h06}}, HOLD);
    applyStimulus(7'h00, 4'b0000, 2);
    checkOutput("coinc first digits", frameIf.frame_digits, 16'h1111);
    scanFrame({4{7'h5B}}, HOLD);
    target = accCount + 1;
    frameIf.frame_ready = 1'b1;
    applyStimulus(7'h00, 4'b0000, 1);
    frameIf.frame_ready = 1'b0;
    checkOutput("coinc valid held", frameIf.frame_valid, 1'b1);
    checkOutput("coinc new digits", frameIf.frame_digits, 16'h2222);
    checkOutput("coinc no overrun", frameIf.overrun, 1'b0);
    checkOutput("coinc accept count", accCount, target);
    checkOutput("coinc accepted old", accDigits, 16'h1111);
    frameIf.frame_ready = 1'b1;
    waitAccept(target + 1, "coinc second");
    checkOutput("coinc second digits", accDigits, 16'h2222);
    checkOutput("coinc valid drop", frameIf.frame_valid, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(7'h06, 4'b0001, HOLD);
    applyStimulus(7'h00, 4'b0000, 1);
    applyStimulus(7'h5B, 4'b0010, HOLD);
    applyStimulus(7'h00, 4'b0000, 1);
    doReset();
    target = accCount + 1;
    scanFrame({7'h7F, 7'h07, 7'h7D, 7'h6D}, HOLD);
    waitAccept(target, "midrst");
    checkFrame("midrst", 16'h8765, 4'b0000, 1'b0);
    applyStimulus(7'h00, 4'b0000, 10);
    checkOutput("midrst single frame", accCount, target);

    $display("[TB] randomized frames against reference model");
    for (int f = 0; f < 20; f++) begin
      eD = '0;
      eB = '0;
      eE = 1'b0;
      for (int d = 0; d < 4; d++) begin
        k = $urandom_range(0, 19);
        if (k < 16)       p = legalPat[k];
        else if (k == 16) p = 7'h00;
        else              p = 7'($urandom_range(0, 127));
        pats[7*d +: 7] = p;
        refDecode(p, v, b, e);
        eD[4*d +: 4] = v;
        eB[d] = b;
        eE = eE | e;
      end
      target = accCount + 1;
      scanFrame(pats, $urandom_range(4, 10));
      waitAccept(target, $sformatf("rand%0d", f));
      checkFrame($sformatf("rand%0d", f), eD, eB, eE);
    end
    checkOutput("rand no overrun", frameIf.overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
